// File: rtl/arm_banked_regfile.sv
// ARM7TDMI-style banked register file: mode-banked GPRs, PC with auto-increment,
// CPSR, per-mode SPSRs, single-cycle exception entry and return.
module arm_banked_regfile #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned PC_INC    = 4,
  parameter int unsigned PC_RD_OFS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  input  logic [3:0]        rd_addr_c,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic              wr_en_a,
  input  logic              wr_en_b,
  input  logic [3:0]        wr_addr_a,
  input  logic [3:0]        wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              pc_inc_en,
  output logic [DATA_W-1:0] pc_out,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  input  logic              cpsr_we,
  input  logic              spsr_we,
  input  logic [31:0]       psr_wdata,
  input  logic              exc_req,
  input  logic [4:0]        exc_mode,
  input  logic [DATA_W-1:0] exc_vector,
  input  logic [DATA_W-1:0] exc_lr,
  input  logic              ret_req,
  output logic [31:0]       cpsr_out,
  output logic [31:0]       spsr_out,
  output logic              mode_err
);

  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } mode_e;

  localparam int unsigned NUM_PHYS = 30;
  localparam logic [31:0] PSR_MASK  = 32'hF000_00FF;
  localparam logic [31:0] CPSR_RST  = 32'h0000_00D3;

  function automatic logic mode_legal(input logic [4:0] m);
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: mode_legal = 1'b1;
      default:                      mode_legal = 1'b0;
    endcase
  endfunction

  // {valid, slot}: only exception modes own an SPSR
  function automatic logic [3:0] spsr_slot(input logic [4:0] m);
    case (m)
      MODE_FIQ: spsr_slot = {1'b1, 3'd0};
      MODE_IRQ: spsr_slot = {1'b1, 3'd1};
      MODE_SVC: spsr_slot = {1'b1, 3'd2};
      MODE_ABT: spsr_slot = {1'b1, 3'd3};
      MODE_UND: spsr_slot = {1'b1, 3'd4};
      default:  spsr_slot = '0;
    endcase
  endfunction

  // Physical layout: 0-14 user bank, 15-21 FIQ r8-r14, then r13/r14 pairs for IRQ, SVC, ABT, UND
  function automatic logic [4:0] bank_idx(input logic [4:0] m, input logic [3:0] r);
    bank_idx = {1'b0, r};
    if (m == MODE_FIQ && r >= 4'd8) begin
      bank_idx = 5'd7 + {1'b0, r};
    end else if (r >= 4'd13) begin
      case (m)
        MODE_IRQ: bank_idx = 5'd9  + {1'b0, r};
        MODE_SVC: bank_idx = 5'd11 + {1'b0, r};
        MODE_ABT: bank_idx = 5'd13 + {1'b0, r};
        MODE_UND: bank_idx = 5'd15 + {1'b0, r};
        default:  bank_idx = {1'b0, r};
      endcase
    end
  endfunction

  logic [DATA_W-1:0] gpr_q  [NUM_PHYS];
  logic [DATA_W-1:0] gpr_d  [NUM_PHYS];
  logic [31:0]       spsr_q [5];
  logic [31:0]       spsr_d [5];
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [31:0]       cpsr_q, cpsr_d;
  logic              mode_err_q, mode_err_d;

  logic [4:0]        cur_mode;
  logic [3:0]        cur_slot;
  logic [3:0]        exc_slot;
  logic [31:0]       cur_spsr;
  logic [DATA_W-1:0] pc_rd;

  assign cur_mode = cpsr_q[4:0];
  assign cur_slot = spsr_slot(cur_mode);
  assign exc_slot = spsr_slot(exc_mode);
  assign cur_spsr = cur_slot[3] ? spsr_q[cur_slot[2:0]] : '0;
  assign pc_rd    = pc_q + DATA_W'(PC_RD_OFS);

  assign rd_data_a = (rd_addr_a == 4'd15) ? pc_rd : gpr_q[bank_idx(cur_mode, rd_addr_a)];
  assign rd_data_b = (rd_addr_b == 4'd15) ? pc_rd : gpr_q[bank_idx(cur_mode, rd_addr_b)];
  assign rd_data_c = (rd_addr_c == 4'd15) ? pc_rd : gpr_q[bank_idx(cur_mode, rd_addr_c)];

  assign pc_out   = pc_q;
  assign cpsr_out = cpsr_q;
  assign spsr_out = cur_spsr;
  assign mode_err = mode_err_q;

  always_comb begin
    gpr_d      = gpr_q;
    spsr_d     = spsr_q;
    pc_d       = pc_q;
    cpsr_d     = cpsr_q;
    mode_err_d = 1'b0;

    if (exc_req) begin
      // An exception request owns the whole cycle, legal or not
      if (exc_slot[3]) begin
        spsr_d[exc_slot[2:0]]          = cpsr_q;
        gpr_d[bank_idx(exc_mode, 4'd14)] = exc_lr;
        pc_d                           = exc_vector;
        cpsr_d = {cpsr_q[31:8], 1'b1, (exc_mode == MODE_FIQ) | cpsr_q[6], 1'b0, exc_mode};
      end else begin
        mode_err_d = 1'b1;
      end
    end else begin
      if (pc_inc_en) pc_d = pc_q + DATA_W'(PC_INC);

      // Port B first so that port A wins on a shared address
      if (wr_en_b) begin
        if (wr_addr_b == 4'd15) pc_d = wr_data_b;
        else                    gpr_d[bank_idx(cur_mode, wr_addr_b)] = wr_data_b;
      end
      if (wr_en_a) begin
        if (wr_addr_a == 4'd15) pc_d = wr_data_a;
        else                    gpr_d[bank_idx(cur_mode, wr_addr_a)] = wr_data_a;
      end

      if (ret_req) begin
        if (cur_slot[3] && mode_legal(cur_spsr[4:0])) cpsr_d = cur_spsr & PSR_MASK;
        else                                         mode_err_d = 1'b1;
      end else if (cpsr_we) begin
        if (!mode_legal(psr_wdata[4:0]))  mode_err_d = 1'b1;
        else if (cur_mode == MODE_USR)    cpsr_d = {psr_wdata[31:28], cpsr_q[27:0]};
        else                              cpsr_d = psr_wdata & PSR_MASK;
      end else if (flags_we) begin
        cpsr_d = {flags_in, cpsr_q[27:0]};
      end

      if (spsr_we) begin
        if (cur_slot[3]) spsr_d[cur_slot[2:0]] = psr_wdata & PSR_MASK;
        else             mode_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) gpr_q[i] <= '0;
      for (int unsigned i = 0; i < 5; i++)        spsr_q[i] <= '0;
      pc_q       <= DATA_W'(RESET_PC);
      cpsr_q     <= CPSR_RST;
      mode_err_q <= 1'b0;
    end else begin
      gpr_q      <= gpr_d;
      spsr_q     <= spsr_d;
      pc_q       <= pc_d;
      cpsr_q     <= cpsr_d;
      mode_err_q <= mode_err_d;
    end
  end

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Bench for arm_banked_regfile: directed scenarios plus random traffic against a
// mode/register-keyed behavioural model compared every cycle.
module tb_arm_banked_regfile;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rd_addr_a, rd_addr_b, rd_addr_c;
  logic [31:0] rd_data_a, rd_data_b, rd_data_c;
  logic        wr_en_a, wr_en_b;
  logic [3:0]  wr_addr_a, wr_addr_b;
  logic [31:0] wr_data_a, wr_data_b;
  logic        pc_inc_en;
  logic [31:0] pc_out;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic        cpsr_we, spsr_we;
  logic [31:0] psr_wdata;
  logic        exc_req;
  logic [4:0]  exc_mode;
  logic [31:0] exc_vector, exc_lr;
  logic        ret_req;
  logic [31:0] cpsr_out, spsr_out;
  logic        mode_err;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  arm_banked_regfile #(.DATA_W(32), .RESET_PC(0), .PC_INC(4), .PC_RD_OFS(8)) dut (
    .clock(clock), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .pc_inc_en(pc_inc_en), .pc_out(pc_out),
    .flags_we(flags_we), .flags_in(flags_in), .cpsr_we(cpsr_we), .spsr_we(spsr_we),
    .psr_wdata(psr_wdata), .exc_req(exc_req), .exc_mode(exc_mode), .exc_vector(exc_vector),
    .exc_lr(exc_lr), .ret_req(ret_req), .cpsr_out(cpsr_out), .spsr_out(spsr_out),
    .mode_err(mode_err)
  );

  // Behavioural model: registers keyed by (owning mode, register number)
  bit [31:0] m_reg  [int];
  bit [31:0] m_spsr [int];
  bit [31:0] m_cpsr, m_pc;
  bit        m_err;

  function automatic bit legal(bit [4:0] m);
    return m inside {5'h10, 5'h1F, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B};
  endfunction

  function automatic bit has_spsr(bit [4:0] m);
    return legal(m) && m != 5'h10 && m != 5'h1F;
  endfunction

  function automatic int key(bit [4:0] m, int r);
    int owner;
    owner = 16;
    if ((m == 5'h11 && r >= 8) || (r >= 13 && has_spsr(m))) owner = int'(m);
    return owner * 100 + r;
  endfunction

  function automatic bit [31:0] greg(bit [4:0] m, int r);
    int k;
    k = key(m, r);
    return m_reg.exists(k) ? m_reg[k] : 32'h0;
  endfunction

  function automatic bit [31:0] gspsr(bit [4:0] m);
    if (!has_spsr(m)) return 32'h0;
    return m_spsr.exists(int'(m)) ? m_spsr[int'(m)] : 32'h0;
  endfunction

  function automatic bit [31:0] exp_rd(logic [3:0] a);
    if (a == 4'd15) return m_pc + 32'd8;
    return greg(m_cpsr[4:0], int'(a));
  endfunction

  task automatic model_reset();
    m_reg.delete();
    m_spsr.delete();
    m_cpsr = 32'h0000_00D3;
    m_pc   = 32'h0;
    m_err  = 1'b0;
  endtask

  task automatic model_write(bit [4:0] cur, logic [3:0] a, logic [31:0] d);
    if (a == 4'd15) m_pc = d;
    else            m_reg[key(cur, int'(a))] = d;
  endtask

  task automatic model_step();
    bit [4:0]  cur;
    bit [31:0] ncpsr, sp;
    bit        err;
    cur   = m_cpsr[4:0];
    ncpsr = m_cpsr;
    err   = 1'b0;
    if (exc_req) begin
      if (has_spsr(exc_mode)) begin
        m_spsr[int'(exc_mode)] = m_cpsr;
        m_reg[key(exc_mode, 14)] = exc_lr;
        m_pc  = exc_vector;
        ncpsr = (m_cpsr & 32'hF000_0040) | 32'h80 | {27'h0, exc_mode};
        if (exc_mode == 5'h11) ncpsr = ncpsr | 32'h40;
      end else err = 1'b1;
    end else begin
      if (pc_inc_en) m_pc = m_pc + 32'd4;
      if (wr_en_b) model_write(cur, wr_addr_b, wr_data_b);
      if (wr_en_a) model_write(cur, wr_addr_a, wr_data_a);
      sp = gspsr(cur);
      if (ret_req) begin
        if (has_spsr(cur) && legal(sp[4:0])) ncpsr = sp & 32'hF000_00FF;
        else err = 1'b1;
      end else if (cpsr_we) begin
        if (!legal(psr_wdata[4:0])) err = 1'b1;
        else if (cur == 5'h10)      ncpsr = {psr_wdata[31:28], m_cpsr[27:0]};
        else                        ncpsr = psr_wdata & 32'hF000_00FF;
      end else if (flags_we) begin
        ncpsr[31:28] = flags_in;
      end
      if (spsr_we) begin
        if (has_spsr(cur)) m_spsr[int'(cur)] = psr_wdata & 32'hF000_00FF;
        else err = 1'b1;
      end
    end
    m_cpsr = ncpsr;
    m_err  = err;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("cpsr", cpsr_out, m_cpsr);
    chk("spsr", spsr_out, gspsr(m_cpsr[4:0]));
    chk("pc", pc_out, m_pc);
    chk("mode_err", {31'h0, mode_err}, {31'h0, m_err});
    chk("rd_a", rd_data_a, exp_rd(rd_addr_a));
    chk("rd_b", rd_data_b, exp_rd(rd_addr_b));
    chk("rd_c", rd_data_c, exp_rd(rd_addr_c));
  end

  task automatic clear_ctl();
    wr_en_a = 0; wr_en_b = 0; wr_addr_a = 0; wr_addr_b = 0; wr_data_a = 0; wr_data_b = 0;
    pc_inc_en = 0; flags_we = 0; flags_in = 0; cpsr_we = 0; spsr_we = 0; psr_wdata = 0;
    exc_req = 0; exc_mode = 0; exc_vector = 0; exc_lr = 0; ret_req = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clear_ctl();
  endtask

  task automatic peek();
    @(negedge clock);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en_a = 1; wr_addr_a = a; wr_data_a = d;
    step();
  endtask

  task automatic set_cpsr(input logic [31:0] v);
    cpsr_we = 1; psr_wdata = v;
    step();
  endtask

  bit [4:0] modes [8] = '{5'h10, 5'h1F, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h05};

  function automatic logic [4:0] pick_mode();
    int i;
    i = $urandom_range(0, 7);
    if (i == 7) return 5'($urandom_range(0, 31));
    return modes[i];
  endfunction

  initial begin
    clear_ctl();
    rd_addr_a = 0; rd_addr_b = 4'd15; rd_addr_c = 0;
    #1 reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;

    peek();
    chk("rst_cpsr", cpsr_out, 32'h0000_00D3);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_r0", rd_data_a, 32'h0);
    chk("rst_r15", rd_data_b, 32'h8);
    chk("rst_spsr", spsr_out, 32'h0);
    #1;

    rd_addr_a = 4'd13;
    wr(4'd13, 32'h1000);
    set_cpsr(32'h1F);
    wr(4'd13, 32'h2000);
    peek(); chk("sys_r13", rd_data_a, 32'h2000); #1;
    set_cpsr(32'hD3);
    peek(); chk("svc_r13", rd_data_a, 32'h1000); #1;

    rd_addr_a = 4'd8;
    set_cpsr(32'h1F);
    wr(4'd8, 32'hAA);
    set_cpsr(32'hD1);
    wr(4'd8, 32'h55);
    peek(); chk("fiq_r8", rd_data_a, 32'h55); #1;
    set_cpsr(32'h1F);
    peek(); chk("usr_r8", rd_data_a, 32'hAA); #1;

    rd_addr_a = 4'd14;
    wr(4'd14, 32'hBEEF);
    set_cpsr(32'h6000_001F);
    exc_req = 1; exc_mode = 5'b10010; exc_vector = 32'h18; exc_lr = 32'h104;
    step();
    peek();
    chk("irq_cpsr", cpsr_out, 32'h6000_0092);
    chk("irq_spsr", spsr_out, 32'h6000_001F);
    chk("irq_lr", rd_data_a, 32'h104);
    chk("irq_pc", pc_out, 32'h18);
    #1;
    ret_req = 1;
    step();
    peek();
    chk("ret_cpsr", cpsr_out, 32'h6000_001F);
    chk("ret_lr", rd_data_a, 32'hBEEF);
    #1;

    rd_addr_a = 4'd3; rd_addr_c = 4'd15;
    wr_en_a = 1; wr_addr_a = 4'd3; wr_data_a = 32'h11;
    wr_en_b = 1; wr_addr_b = 4'd3; wr_data_b = 32'h22;
    step();
    peek(); chk("port_a_wins", rd_data_a, 32'h11); #1;
    pc_inc_en = 1;
    wr(4'd15, 32'h200);
    peek(); chk("pc_wr_over_inc", pc_out, 32'h200); #1;
    wr(4'd15, 32'hFFFF_FFFC);
    peek(); chk("r15_rd_wrap", rd_data_c, 32'h4); #1;
    pc_inc_en = 1;
    step();
    peek(); chk("pc_wrap", pc_out, 32'h0); #1;

    set_cpsr(32'h0000_00C5);
    peek();
    chk("bad_cpsr_keep", cpsr_out, 32'h6000_001F);
    chk("bad_cpsr_err", {31'h0, mode_err}, 32'h1);
    #1;
    step();
    peek(); chk("err_one_cycle", {31'h0, mode_err}, 32'h0); #1;
    ret_req = 1;
    step();
    peek(); chk("ret_sys_err", {31'h0, mode_err}, 32'h1); #1;

    exc_req = 1; exc_mode = 5'b10001; exc_vector = 32'h1C; exc_lr = 32'h50;
    step();
    #2 reset = 1;
    peek();
    chk("mid_rst_cpsr", cpsr_out, 32'h0000_00D3);
    chk("mid_rst_pc", pc_out, 32'h0);
    chk("mid_rst_r3", rd_data_a, 32'h0);
    chk("mid_rst_spsr", spsr_out, 32'h0);
    #1;
    step();
    reset = 0;

    repeat (3000) begin
      rd_addr_a = 4'($urandom_range(0, 15));
      rd_addr_b = 4'($urandom_range(0, 15));
      rd_addr_c = 4'($urandom_range(0, 15));
      wr_en_a   = ($urandom_range(0, 2) == 0);
      wr_addr_a = 4'($urandom_range(0, 15));
      wr_data_a = 32'($urandom);
      wr_en_b   = ($urandom_range(0, 2) == 0);
      wr_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr_a : 4'($urandom_range(0, 15));
      wr_data_b = 32'($urandom);
      pc_inc_en = ($urandom_range(0, 1) == 0);
      flags_we  = ($urandom_range(0, 5) == 0);
      flags_in  = 4'($urandom_range(0, 15));
      cpsr_we   = ($urandom_range(0, 9) == 0);
      spsr_we   = ($urandom_range(0, 11) == 0);
      psr_wdata = (32'($urandom) & 32'hFFFF_FFE0) | {27'h0, pick_mode()};
      ret_req   = ($urandom_range(0, 15) == 0);
      exc_req   = ($urandom_range(0, 19) == 0);
      exc_mode  = pick_mode();
      exc_vector = 32'($urandom);
      exc_lr     = 32'($urandom);
      @(posedge clock);
      #1;
    end
    clear_ctl();
    step();
    peek();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
